// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    localparam logic [31:0] UART_TXDATA_OFFSET = 32'd0;
    localparam logic [31:0] UART_STATUS_OFFSET = 32'd4;

    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_BUSY_BIT   = 2;
    localparam int STATUS_OVF_BIT    = 3;
    localparam int STATUS_COUNT_LSB  = 4;
    localparam int STATUS_PARITY_BIT = 8;

    // The STATUS count field is only 4 bits wide, so deep FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Reusable synchronous FIFO with wrap-bit full/empty detection and first-word fall-through read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when an entry leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, byte FIFO and 8N1 frame FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int              CW      = $clog2(CLKS_PER_BIT);
    localparam int              FCW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

    uart_state_t    state, next_state;
    logic [CW-1:0]  cnt;
    logic [7:0]     shift;
    logic [2:0]     bit_idx;
    logic           overflow;
    logic           tx_push, stat_wr, ovf_clr;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [FCW-1:0] fifo_count;
    logic [31:0]    status;
    logic           unused_bits;
`ifdef UART_TX_PARITY_EN
    logic           parity_bit;
`endif

    assign tx_push     = we[0] && (addr == BASE_ADDR + UART_TXDATA_OFFSET);
    assign stat_wr     = we[0] && (addr == BASE_ADDR + UART_STATUS_OFFSET);
    assign ovf_clr     = stat_wr && wdata[STATUS_OVF_BIT];
    assign unused_bits = ^{we[3:1], wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (fifo_pop),
        .wdata (wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped byte wins over a clear on the same edge so the loss is never hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    overflow <= 1'b0;
        else if (tx_push && fifo_full && !fifo_pop)   overflow <= 1'b1;
        else if (ovf_clr)                             overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= UART_IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            UART_IDLE:   if (!fifo_empty) next_state = UART_START;
            UART_START:  if (cnt == '0) next_state = UART_DATA;
            UART_DATA:
                if (cnt == '0 && bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                    next_state = UART_PARITY;
`else
                    next_state = UART_STOP;
`endif
            UART_PARITY: if (cnt == '0) next_state = UART_STOP;
            UART_STOP:   if (cnt == '0) next_state = fifo_empty ? UART_IDLE : UART_START;
            default:     next_state = UART_IDLE;
        endcase
    end

    // Bytes leave the FIFO only on entry to START, whether from IDLE or back-to-back from STOP.
    assign fifo_pop = (next_state == UART_START) && (state != UART_START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (fifo_pop) begin
            shift <= fifo_rdata;
            cnt   <= CNT_MAX;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_rdata;
`endif
        end else if (state != UART_IDLE) begin
            cnt <= (cnt == '0) ? CNT_MAX : cnt - 1'b1;
            if (state == UART_START && cnt == '0) bit_idx <= '0;
            if (state == UART_DATA && cnt == '0) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            UART_START:  tx = 1'b0;
            UART_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
            UART_PARITY: tx = parity_bit;
`endif
            default:     tx = 1'b1;
        endcase
    end

    assign busy = (state != UART_IDLE) || !fifo_empty;
    assign hit  = (addr[31:3] == BASE_ADDR[31:3]);

    always_comb begin
        status                                 = '0;
        status[STATUS_FULL_BIT]                = fifo_full;
        status[STATUS_EMPTY_BIT]               = fifo_empty;
        status[STATUS_BUSY_BIT]                = busy;
        status[STATUS_OVF_BIT]                 = overflow;
        status[STATUS_COUNT_LSB +: 4]          = sat_count4(32'(fifo_count));
`ifdef UART_TX_PARITY_EN
        status[STATUS_PARITY_BIT]              = 1'b1;
`endif
    end

    assign rdata = (hit && addr[2:0] == UART_STATUS_OFFSET[2:0]) ? status : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] STAT  = 32'h0000_1004;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FB    = 11;
    localparam logic [31:0] PAR   = 32'h0000_0100;
`else
    localparam int          FB    = 10;
    localparam logic [31:0] PAR   = 32'h0000_0000;
`endif
    localparam int          FRAME = FB * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  we;
    logic        hit, tx, busy;
    int          errors = 0;
    int          checks = 0;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .hit   (hit),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Expected line level for a given cycle slot of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        int k;
        k = slot / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        addr = a; wdata = d; we = e;
        @(posedge clk); #1;
        we = 4'b0000;
    endtask

    task automatic read_status(output logic [31:0] d);
        addr = STAT; we = 4'b0000;
        #1 d = rdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Samples n consecutive frames and counts slots where tx or busy disagree with the model.
    task automatic sample_frames(input logic [7:0] bytes [8], input int n, input int start_slot,
                                 output int bad, output int first_bad);
        bad = 0; first_bad = -1;
        for (int f = 0; f < n; f++) begin
            for (int s = (f == 0) ? start_slot : 0; s < FRAME; s++) begin
                @(posedge clk); #1;
                if (tx !== frame_bit(bytes[f], s) || busy !== 1'b1) begin
                    if (bad == 0) first_bad = f * FRAME + s;
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] st;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        read_status(st);
        checks++; if (st !== (32'h02 | PAR)) begin errors++; $display("FAIL reset_status: got %h want %h", st, 32'h02 | PAR); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_status: got %b want 1", hit); end
        addr = BASE; #1;
        checks++; if (hit !== 1'b1 || rdata !== 32'd0) begin errors++; $display("FAIL txdata_read: hit=%b rdata=%h want 1/0", hit, rdata); end
        addr = BASE + 32'd8; #1;
        checks++; if (hit !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL miss_above: hit=%b rdata=%h want 0/0", hit, rdata); end
        addr = BASE - 32'd4; #1;
        checks++; if (hit !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL miss_below: hit=%b rdata=%h want 0/0", hit, rdata); end
        wait_cycles(1);
    endtask

    task automatic test_single_byte;
        logic [7:0] bytes [8];
        int bad, first_bad;
        bytes = '{default: 8'h00};
        bytes[0] = 8'h55;
        write_reg(BASE, 32'hDEAD_BE55, 4'b0001);
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_latency: tx=%b busy=%b want 1/1", tx, busy); end
        sample_frames(bytes, 1, 0, bad, first_bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_frame: %0d bad slots (first %0d) want 0", bad, first_bad); end
        wait_cycles(1);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_done: busy=%b tx=%b want 0/1", busy, tx); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] st;
        write_reg(BASE, 32'h00, 4'b0001);
        write_reg(BASE, 32'h00, 4'b0001);
        wait_cycles(7);
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midframe_pre: tx=%b busy=%b want 0/1", tx, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midframe_reset: tx=%b busy=%b want 1/0", tx, busy); end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        read_status(st);
        checks++; if (st !== (32'h02 | PAR) || tx !== 1'b1) begin errors++; $display("FAIL midframe_status: st=%h tx=%b want %h/1", st, tx, 32'h02 | PAR); end
    endtask

    task automatic test_byte_lane;
        logic [31:0] st;
        int bad;
        write_reg(BASE, 32'h0000_00FF, 4'b0010);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lane_idle: %0d bad cycles want 0", bad); end
        read_status(st);
        checks++; if (st !== (32'h02 | PAR)) begin errors++; $display("FAIL lane_status: got %h want %h", st, 32'h02 | PAR); end
    endtask

    task automatic test_overflow;
        logic [7:0]  bytes [8];
        logic [31:0] st;
        int bad, first_bad;
        bytes = '{default: 8'h00};
        addr = BASE; we = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            wdata = 32'hA0 + i;
            bytes[i] = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        we = 4'b0000;
        read_status(st);
        checks++; if (st !== (32'h4D | PAR)) begin errors++; $display("FAIL ovf_status: got %h want %h", st, 32'h4D | PAR); end
        sample_frames(bytes, 5, 5, bad, first_bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_frames: %0d bad slots (first %0d) want 0", bad, first_bad); end
        wait_cycles(1);
        read_status(st);
        checks++; if (st !== (32'h0A | PAR)) begin errors++; $display("FAIL ovf_sticky: got %h want %h", st, 32'h0A | PAR); end
        write_reg(STAT, 32'h08, 4'b0001);
        read_status(st);
        checks++; if (st !== (32'h02 | PAR)) begin errors++; $display("FAIL ovf_clear: got %h want %h", st, 32'h02 | PAR); end
    endtask

    task automatic test_full_pop;
        logic [7:0]  bytes [8];
        logic [31:0] st;
        int bad, first_bad;
        bytes = '{default: 8'h00};
        addr = BASE; we = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            wdata = 32'hC0 + i;
            if (i > 0) bytes[i-1] = 8'hC0 + 8'(i);
            @(posedge clk); #1;
        end
        we = 4'b0000;
        bytes[4] = 8'hC5;
        read_status(st);
        checks++; if (st !== (32'h45 | PAR)) begin errors++; $display("FAIL fullpop_filled: got %h want %h", st, 32'h45 | PAR); end
        wait_cycles(FRAME - 4);
        write_reg(BASE, 32'hC5, 4'b0001);
        read_status(st);
        checks++; if (st !== (32'h45 | PAR)) begin errors++; $display("FAIL fullpop_status: got %h want %h", st, 32'h45 | PAR); end
        sample_frames(bytes, 5, 1, bad, first_bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL fullpop_frames: %0d bad slots (first %0d) want 0", bad, first_bad); end
        wait_cycles(1);
        read_status(st);
        checks++; if (st !== (32'h02 | PAR)) begin errors++; $display("FAIL fullpop_done: got %h want %h", st, 32'h02 | PAR); end
    endtask

    task automatic test_parity;
        logic [7:0]  bytes [8];
        logic [31:0] st;
        int bad, first_bad;
        bytes = '{default: 8'h00};
        bytes[0] = 8'h07;
        bytes[1] = 8'h03;
        write_reg(BASE, 32'h07, 4'b0001);
        write_reg(BASE, 32'h03, 4'b0001);
        sample_frames(bytes, 2, 1, bad, first_bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL parity_frames: %0d bad slots (first %0d) want 0", bad, first_bad); end
        wait_cycles(1);
        read_status(st);
        checks++; if (st !== (32'h02 | PAR)) begin errors++; $display("FAIL parity_status: got %h want %h", st, 32'h02 | PAR); end
    endtask

    initial begin
        reset = 1'b1; addr = 32'd0; wdata = 32'd0; we = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_single_byte;
        test_reset_midframe;
        test_byte_lane;
        test_overflow;
        test_full_pop;
        test_parity;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
